// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory access unit: sizes, FSM states,
// default read latency and the alignment rule.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  // Illegal size, or a half/word whose address is not naturally aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) ||
           ((size == SZ_H) && lo[0]) ||
           ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mau_align.sv
// Little-endian lane logic: extracts and extends load data, and merges
// store data into the old memory word for sub-word writes.
module mau_align
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] lane_mask;

  assign shifted   = rword_i >> {lane_i, 3'b000};
  assign lane_mask = mask << {lane_i, 3'b000};
  assign merged_o  = (rword_i & ~lane_mask) | ((wdata_i << {lane_i, 3'b000}) & lane_mask);

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    load_data_o = rword_i;
    mask        = 32'hFFFF_FFFF;
    case (size_i)
      SZ_B: begin
        mask        = 32'h0000_00FF;
        load_data_o = is_unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        mask        = 32'h0000_FFFF;
        load_data_o = is_unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store per handshake, with read-modify-write
// for sub-word stores and early rejection of misaligned/illegal requests.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned AW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mRead,
  output logic          mWrite,
  output logic [AW-1:0] addr_out,
  output logic [31:0]   write_data,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned   CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic          uns_q, uns_d;
  logic          err_q, err_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wr_word_q, wr_word_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic          req_bad;

  assign req_bad = misaligned(req_size, req_addr[1:0]);

  mau_align u_align (
    .size_i        (size_q),
    .lane_i        (lane_q),
    .is_unsigned_i (uns_q),
    .rword_i       (m_rdata),
    .wdata_i       (wdata_q),
    .load_data_o   (load_data),
    .merged_o      (merged)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[AW-1:2], 2'b00};
          lane_d  = req_addr[1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          err_d   = req_bad;
          cnt_d   = '0;
          rdata_d = '0;
          if (req_bad) begin
            state_d = ST_RESP;
          end else if (req_we && (req_size == SZ_W)) begin
            state_d   = ST_WR;
            wr_word_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // The last read cycle captures memory data: loads finish, sub-word stores merge.
        if (cnt_q == CNT_LAST) begin
          if (we_q) begin
            state_d   = ST_WR;
            wr_word_d = merged;
          end else begin
            state_d = ST_RESP;
            rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mRead      = (state_q == ST_RD);
  assign mWrite     = (state_q == ST_WR);
  assign addr_out   = addr_q;
  assign write_data = wr_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a reference memory/latency model predicts every response
// of an RD_LAT=1 unit; a second RD_LAT=3 unit is checked for timing and merge.
module tb_mem_access_unit;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- unit A (RD_LAT=1) ----------------
  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err, a_mRead, a_mWrite;
  logic [31:0] a_resp_rdata, a_addr_out, a_write_data, a_m_rdata;

  logic [31:0] mem_a   [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};

  assign a_m_rdata = mem_a[a_addr_out[7:2]];
  always @(posedge clk) if (a_mWrite) mem_a[a_addr_out[7:2]] <= a_write_data;

  mem_access_unit #(.RD_LAT(LAT_A), .AW(32)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .mRead(a_mRead), .mWrite(a_mWrite), .addr_out(a_addr_out),
    .write_data(a_write_data), .m_rdata(a_m_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] waddr;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_mRead && a_mWrite) check("rd_wr_exclusive", 32'(1), 32'(0));
      if (q.size() > 0) begin
        if (a_mRead) rd_cnt++;
        if (a_mWrite) wr_cnt++;
        if (a_mRead || a_mWrite) check("addr_out", a_addr_out, q[0].waddr);
        if (a_resp_valid) begin
          check("resp_rdata", a_resp_rdata, q[0].rdata);
          check("resp_err", 32'(a_resp_err), 32'(q[0].err));
          check("resp_latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          check("mread_cycles", 32'(rd_cnt), 32'(q[0].rd));
          check("mwrite_cycles", 32'(wr_cnt), 32'(q[0].wr));
          last_rdata = a_resp_rdata;
          void'(q.pop_front());
        end
      end else begin
        if (a_resp_valid) check("spurious_resp", 32'(1), 32'(0));
        if (a_mWrite) check("spurious_write", 32'(1), 32'(0));
      end
    end
  end

  task automatic wait_ready_a();
    int n;
    n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) check("ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic drive_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_req_we = we; a_req_size = size; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wdata; a_req_valid = 1'b1;
  endtask

  task automatic scramble_a();
    a_req_valid = 1'b0; a_req_we = ~a_req_we; a_req_size = 2'b11;
    a_req_addr = 32'hDEAD_BEEF; a_req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          idx, lo, nb;
    logic [31:0] w, part;
    idx = int'(addr[7:2]);
    lo  = int'(addr[1:0]);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && lo != 0);
    e.waddr = addr & 32'hFFFF_FFFC;
    e.rdata = 32'h0; e.rd = 0; e.wr = 0; e.lat = 1;
    w = ref_mem[idx];
    if (!e.err && !we) begin
      e.lat = LAT_A + 1;
      e.rd  = LAT_A;
      if (nb == 4) e.rdata = w;
      else begin
        part = (w >> (8 * lo)) & ((nb == 1) ? 32'hFF : 32'hFFFF);
        if (!uns && part >= ((nb == 1) ? 32'd128 : 32'd32768))
          part = part - ((nb == 1) ? 32'd256 : 32'd65536);
        e.rdata = part;
      end
    end else if (!e.err) begin
      e.wr  = 1;
      e.lat = (nb == 4) ? 2 : LAT_A + 2;
      e.rd  = (nb == 4) ? 0 : LAT_A;
      for (int k = 0; k < nb; k++) w[8*(lo+k) +: 8] = wdata[8*k +: 8];
      ref_mem[idx] = w;
    end
    wait_ready_a();
    drive_a(we, size, uns, addr, wdata);
    e.acc = cyc;
    rd_cnt = 0;
    wr_cnt = 0;
    q.push_back(e);
    @(posedge clk);
    #1 scramble_a();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("resp_timeout", 32'(0), 32'(1));
      q.delete();
    end
  endtask

  // ---------------- unit B (RD_LAT=3) ----------------
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err, b_mRead, b_mWrite;
  logic [31:0] b_resp_rdata, b_addr_out, b_write_data, b_m_rdata;

  logic [31:0] mem_b [64] = '{default: 32'h0};
  assign b_m_rdata = mem_b[b_addr_out[7:2]];
  always @(posedge clk) if (b_mWrite) mem_b[b_addr_out[7:2]] <= b_write_data;

  mem_access_unit #(.RD_LAT(LAT_B), .AW(32)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mRead(b_mRead), .mWrite(b_mWrite), .addr_out(b_addr_out),
    .write_data(b_write_data), .m_rdata(b_m_rdata)
  );

  task automatic b_req(input string name, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_rd, input logic [31:0] exp_rdata);
    int acc, nrd, n;
    logic got;
    n = 0;
    @(negedge clk);
    while (!b_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    b_req_we = we; b_req_size = size; b_req_unsigned = 1'b0;
    b_req_addr = addr; b_req_wdata = wdata; b_req_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    got = 1'b0;
    nrd = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_mRead) nrd++;
      if (b_resp_valid) begin
        got = 1'b1;
        check({name, "_lat"}, 32'(cyc - acc), 32'(exp_lat));
        check({name, "_mread"}, 32'(nrd), 32'(exp_rd));
        check({name, "_rdata"}, b_resp_rdata, exp_rdata);
        check({name, "_err"}, 32'(b_resp_err), 32'(0));
      end
    end
    if (!got) check({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'b00; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'(1));
    check("rst_resp_valid", 32'(a_resp_valid), 32'(0));
    check("rst_resp_err", 32'(a_resp_err), 32'(0));
    check("rst_strobes", {30'b0, a_mRead, a_mWrite}, 32'(0));
    check("rst_addr_out", a_addr_out, 32'h0);
    check("rst_write_data", a_write_data, 32'h0);
    check("rst_resp_rdata", a_resp_rdata, 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_lw_10", last_rdata, 32'h1234_5678);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0011);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("lit_lw_20", last_rdata, 32'hAABB_11DD);
    check("lit_mem_20", mem_a[8], 32'hAABB_11DD);

    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    check("lit_lb_23", last_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    check("lit_lbu_23", last_rdata, 32'h0000_00AA);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    check("lit_lh_22", last_rdata, 32'hFFFF_AABB);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    check("lit_lhu_22", last_rdata, 32'h0000_AABB);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    check("lit_lb_20", last_rdata, 32'hFFFF_FFDD);

    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_FFFF);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_err_no_touch", last_rdata, 32'h1234_5678);

    // Reset lands while the read half of a sub-word store is in flight.
    wait_ready_a();
    drive_a(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_BEEF);
    @(posedge clk);
    #1 scramble_a();
    @(negedge clk);
    check("midrst_in_rd", 32'(a_mRead), 32'(1));
    a_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    check("midrst_ready", 32'(a_req_ready), 32'(1));
    check("midrst_strobes", {30'b0, a_mRead, a_mWrite}, 32'(0));
    check("midrst_no_resp", 32'(a_resp_valid), 32'(0));
    repeat (4) @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("lit_midrst_word", last_rdata, 32'hAABB_11DD);

    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_7788);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_sh_12", last_rdata, 32'h7788_5678);

    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0102_0304);
    do_req(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0);
    check("lit_top_byte", last_rdata, 32'h0000_0001);
    do_req(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_00EE);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("lit_no_carry", last_rdata, 32'hEE02_0304);
    check("lit_no_carry_w0", mem_a[0], 32'h0);

    b_req("b_sw",  1'b1, 2'b10, 32'h40, 32'hCAFE_F00D, 2, 0, 32'h0);
    b_req("b_sb",  1'b1, 2'b00, 32'h43, 32'h0000_005A, LAT_B + 2, LAT_B, 32'h0);
    b_req("b_lw",  1'b0, 2'b10, 32'h40, 32'h0, LAT_B + 1, LAT_B, 32'h5AFE_F00D);
    b_req("b_lh",  1'b0, 2'b01, 32'h42, 32'h0, LAT_B + 1, LAT_B, 32'h0000_5AFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
